load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage downstream of the ALU. Takes the ALU result as an effective address, plus rs2 store data.
//  Runs a byte-lane-aware load/store against a data memory with a req/ack handshake.
//  Returns sign- or zero-extended load data for register writeback.
//  Raises stall to the CPU so the PC holds while an access is in flight.
// PARAMETERS
//  ADDR_W  32  address width (ALU result width)
//  DATA_W  32  data width; fixed at 32 (4 byte lanes)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-high
//  req_valid   in   1       CPU requests a memory op this cycle
//  req_ready   out  1       LSU can accept a request (IDLE only)
//  req_store   in   1       1=store, 0=load
//  req_funct3  in   3       RISC-V funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  req_addr    in   ADDR_W  effective address (ALU result)
//  req_wdata   in   DATA_W  store data (rs2)
//  resp_valid  out  1       1-cycle pulse: op complete
//  resp_rdata  out  DATA_W  extended load data; 0 for stores/illegal
//  stall       out  1       CPU must hold PC/pipeline
//  mem_req     out  1       bus request, held until mem_ack
//  mem_we      out  1       bus write
//  mem_addr    out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
//  mem_wdata   out  DATA_W  store data replicated across lanes
//  mem_be      out  4       byte enables (writes); 4'b1111 on reads
//  mem_ack     in   1       bus completes access; rdata valid same cycle
//  mem_rdata   in   DATA_W  read word
//  misaligned  out  1       (LSU_MISALIGN_TRAP_EN only) 1-cycle pulse with resp_valid
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, mem_req, mem_we, misaligned=0; resp_rdata, mem_addr, mem_wdata=0; mem_be=0.
//  FSM IDLE->BUS->RESP->IDLE.
//  IDLE: req_ready=1. On req_valid, latch op/addr/wdata.
//    Legal op: go to BUS. Illegal funct3 (load 3/6/7, store >=3): go to RESP with no bus access.
//  BUS: mem_req=1, outputs stable until the mem_ack cycle. On mem_ack, capture mem_rdata and go to RESP.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE. Requests are not accepted in RESP.
//  stall = (IDLE & req_valid) | BUS. It is low in RESP so the CPU advances on the resp_valid cycle.
//  Latency: accept at cycle 0; mem_req from cycle 1; mem_ack at cycle k>=1; resp_valid at k+1. Minimum 2.
//  mem_ack while mem_req=0 is ignored.
//  Byte enables:
//    SB: 4'b0001<<addr[1:0]
//    SH: 4'b0011<<{addr[1],1'b0}
//    SW: 4'b1111
//  Store data: SB replicates {4{wdata[7:0]}}; SH replicates {2{wdata[15:0]}}.
//  Load extract: word >> (8*addr[1:0]), then LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
//  Reset mid-op: back to IDLE next edge; mem_req drops; a pending/late ack is dropped; no resp_valid.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    Misaligned access (LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0) goes IDLE->RESP with no bus access.
//    resp_valid=1, misaligned=1, resp_rdata=0.
//  LSU_MISALIGN_TRAP_EN undefined:
//    No misaligned port. Offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]) and the access proceeds.
// STRUCTURE
//  Package lsu_pkg:
//    funct3 constants F3_LB..F3_SW
//    lsu_state_t enum {IDLE,BUS,RESP}
//    functions be_gen(), is_legal(), is_misaligned()
//  Sub-module lsu_align: combinational store-lane steering (be/wdata) and load extract/extend.
//  The FSM, latches and handshake stay in load_store_unit.
// TESTING
//  1. SW addr=0x100 wdata=0xdeadbeef, ack at cycle 1 -> mem_be=1111, mem_addr=0x100; resp_valid at cycle 2.
//  2. LB addr=0x103, mem_rdata=0x80aa55cc -> resp_rdata=0xffffff80.
//     LBU same -> 0x00000080.
//  3. SH addr=0x102 wdata=0x1234 -> mem_be=1100, mem_wdata=0x12341234.
//     LH/LHU at 0x102 from 0x8001xxxx -> 0xffff8001 / 0x00008001.
//  4. LW with ack delayed 5 cycles -> mem_req and stall held high for 5 cycles, mem_addr stable; one resp_valid.
//  5. Reset asserted in BUS, then late mem_ack -> IDLE, mem_req=0, no resp_valid.
//     Illegal load funct3=3 -> resp_valid, rdata 0, mem_req never high.
//  6. LW addr=0x101:
//     with LSU_MISALIGN_TRAP_EN -> misaligned=1, no mem_req.
//     without -> mem_addr=0x100, full word returned.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit: RISC-V funct3 encodings for
//   the supported loads and stores, the LSU state type, and small helper
//   functions for byte-enable generation, legality and alignment checks.
//   No ports; imported by load_store_unit and lsu_align.
// ---------------------------------------------------------------------------
package lsu_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } lsu_state_t;

  // Byte enables for an access of the size encoded in funct3[1:0]
  // starting at byte lane addr_lo.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Loads allow LB/LH/LW/LBU/LHU; stores allow SB/SH/SW only.
  function automatic logic is_legal(input logic store, input logic [2:0] funct3);
    logic ok;
    if (store) begin
      ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      ok = (funct3 == F3_LB)  || (funct3 == F3_LH)  || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end
    return ok;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Data-memory bus between the LSU and the memory.
//   mem_req   LSU -> mem   request, held until mem_ack
//   mem_we    LSU -> mem   write when 1
//   mem_addr  LSU -> mem   word-aligned address
//   mem_wdata LSU -> mem   store data replicated across lanes
//   mem_be    LSU -> mem   byte enables (4'b1111 on reads)
//   mem_ack   mem -> LSU   access complete, mem_rdata valid same cycle
//   mem_rdata mem -> LSU   read word
//   Modports: master (LSU side), slave (memory side).
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Purely combinational byte-lane steering for the LSU.
//   Store side: st_funct3/st_addr_lo/st_wdata -> st_be (byte enables) and
//               st_wdata_lane (store data replicated across the lanes).
//   Load side:  ld_funct3/ld_addr_lo/ld_word  -> ld_data (selected byte or
//               halfword, sign- or zero-extended; words pass unchanged).
//   Data width is fixed at 32 bits (4 byte lanes).
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // Store steering: replicating the data means whichever lanes the byte
  // enables select already hold the right bytes, so no per-lane mux is needed.
  always_comb begin
    st_be = be_gen(st_funct3, st_addr_lo);
    case (st_funct3[1:0])
      2'b00:   st_wdata_lane = {4{st_wdata[7:0]}};
      2'b01:   st_wdata_lane = {2{st_wdata[15:0]}};
      default: st_wdata_lane = st_wdata;
    endcase
  end

  // Load extract: bring the addressed lane down to bit 0, then extend
  // according to the load flavour.
  always_comb begin
    ld_shifted = ld_word >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_shifted[7]}},  ld_shifted[7:0]};
      F3_LH:   ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LBU:  ld_data = {24'd0, ld_shifted[7:0]};
      F3_LHU:  ld_data = {16'd0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory stage after the ALU: runs one byte-lane-aware load or store at a
//   time over a req/ack data bus and returns extended load data.
//   clk, reset       clock (rising edge), synchronous active-high reset
//   req_valid/ready  CPU request handshake (ready only while idle)
//   req_store        1=store, 0=load
//   req_funct3       RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr         effective address from the ALU
//   req_wdata        store data (rs2)
//   resp_valid       one-cycle completion pulse
//   resp_rdata       extended load data, 0 for stores and illegal ops
//   stall            hold the PC while a request is being taken or in flight
//   mem              data-memory bus (load_store_unit_if.master)
//   misaligned       only with LSU_MISALIGN_TRAP_EN: pulses with resp_valid
//                    when the access was rejected for misalignment
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
//   accesses are rejected without a bus cycle; when undefined, the offending
//   low address bits are cleared and the access proceeds.
// DATA_W is fixed at 32.
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              stall,
  load_store_unit_if.master mem
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  lsu_state_t  state;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [1:0]  op_addr_lo;

  logic [1:0]  addr_lo_eff;
  logic        req_legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_lane;
  logic [31:0] ld_data;

  // The CPU sees ready only in IDLE; stall covers the accept cycle and the
  // whole bus phase but drops in RESP so the CPU advances with resp_valid.
  always_comb begin
    req_ready = (state == IDLE);
    stall     = ((state == IDLE) && req_valid) || (state == BUS);
    req_legal = is_legal(req_store, req_funct3);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis;

  // With the trap enabled the address is used as-is; misaligned requests
  // never reach the bus.
  always_comb begin
    addr_lo_eff = req_addr[1:0];
    req_mis     = is_misaligned(req_funct3, req_addr[1:0]);
  end
`else
  // Without the trap, the low bits a halfword or word cannot use are cleared
  // so the access silently lands on the aligned location.
  always_comb begin
    case (req_funct3[1:0])
      2'b01:   addr_lo_eff = {req_addr[1], 1'b0};
      2'b10:   addr_lo_eff = 2'b00;
      default: addr_lo_eff = req_addr[1:0];
    endcase
  end
`endif

  lsu_align u_align (
    .st_funct3     (req_funct3),
    .st_addr_lo    (addr_lo_eff),
    .st_wdata      (req_wdata),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .ld_funct3     (op_funct3),
    .ld_addr_lo    (op_addr_lo),
    .ld_word       (mem.mem_rdata),
    .ld_data       (ld_data)
  );

  // Control FSM. Bus outputs are loaded once at accept time and held
  // untouched through BUS, which keeps them stable until the ack cycle.
  // An ack outside BUS is simply not looked at, and reset returns to IDLE
  // so a late ack after reset is dropped too.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_store      <= 1'b0;
      op_funct3     <= 3'd0;
      op_addr_lo    <= 2'd0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            op_store   <= req_store;
            op_funct3  <= req_funct3;
            op_addr_lo <= addr_lo_eff;
            if (!req_legal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            end else if (req_mis) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              misaligned <= 1'b1;
`endif
            end else begin
              state         <= BUS;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= req_store;
              mem.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem.mem_be    <= req_store ? st_be : 4'b1111;
              mem.mem_wdata <= st_wdata_lane;
            end
          end
        end
        BUS: begin
          if (mem.mem_ack) begin
            state       <= RESP;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            resp_valid  <= 1'b1;
            resp_rdata  <= op_store ? '0 : ld_data;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          misaligned <= 1'b0;
`endif
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Scoreboard bench for load_store_unit. The driver computes each expected
//   bus transaction and response from a byte-array memory model and queues
//   them; a bus responder and a response monitor pop and compare.
//   Honours LSU_MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } resp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .stall      (stall),
    .mem        (bus)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int resp_count = 0;
  int last_resp_cycle = 0;
  int issue_cycle = 0;
  int last_req_cycles = 0;
  int force_delay = -1;
  int ack_mode = 0;

  bus_t  bus_q[$];
  resp_t resp_q[$];

  logic [7:0]  ref_mem [64];
  logic [31:0] bus_mem [16];

  // Free-running clock and a cycle counter that ticks on the active edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: memory as bytes, accesses as byte counts, extension by
  // plain arithmetic. Updates the model memory on stores.
  task automatic modelOp(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic has_bus,
                         output bus_t b, output resp_t r);
    int nbytes;
    int base;
    logic legal;
    logic [31:0] ea;
    logic [31:0] val;
    has_bus = 1'b0;
    b = '{addr: 32'd0, we: 1'b0, be: 4'd0, wdata: 32'd0};
    r = '{rdata: 32'd0, mis: 1'b0};
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (!legal) return;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(a[1:0]) % nbytes) != 0) begin
      r.mis = 1'b1;
      return;
    end
`endif
    ea = a - 32'(int'(a[1:0]) % nbytes);
    base = int'(ea[5:0]);
    has_bus = 1'b1;
    b.addr = {ea[31:2], 2'b00};
    b.we = st;
    for (int i = 0; i < nbytes; i++) b.be[int'(ea[1:0]) + i] = 1'b1;
    if (st) begin
      b.wdata = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
      for (int i = 0; i < nbytes; i++) ref_mem[base + i] = wd[8*i +: 8];
    end else begin
      b.be = 4'b1111;
      val = 32'd0;
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[base + i];
      if (!f3[2] && nbytes < 4 && val[8*nbytes-1])
        val = val | ~((32'd1 << (8*nbytes)) - 32'd1);
      r.rdata = val;
    end
  endtask

  // Issue one request, queue its expectations, and wait (bounded) for the
  // response monitor to see it complete.
  task automatic applyStimulus(input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    int guard;
    int start_count;
    logic hb;
    bus_t b;
    resp_t r;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("ready_timeout", 32'(req_ready), 32'd1);
    modelOp(st, f3, a, wd, hb, b, r);
    if (hb) bus_q.push_back(b);
    resp_q.push_back(r);
    start_count = resp_count;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    issue_cycle = cycle;
    #1;
    checkOutput("stall_on_req", 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    guard = 0;
    while (resp_count == start_count && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) checkOutput("resp_timeout", 32'(resp_count), 32'(start_count + 1));
  endtask

  // Memory responder: checks each new bus request against the queue, holds
  // the ack off for a random or forced number of cycles while checking the
  // request stays put, and throws in stray acks while the bus is idle.
  initial begin
    bit busy;
    int wait_left;
    int req_cycles;
    logic [31:0] first_addr;
    bus_t b;
    busy = 0;
    wait_left = 0;
    req_cycles = 0;
    first_addr = 32'd0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (ack_mode == 2) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = $urandom;
      end else if (bus.mem_req) begin
        if (!busy) begin
          busy = 1;
          req_cycles = 0;
          first_addr = bus.mem_addr;
          wait_left = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
          if (bus_q.size() == 0) begin
            checkOutput("unexpected_mem_req", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            checkOutput("bus_addr", bus.mem_addr, b.addr);
            checkOutput("bus_we", 32'(bus.mem_we), 32'(b.we));
            checkOutput("bus_be", 32'(bus.mem_be), 32'(b.be));
            if (b.we) checkOutput("bus_wdata", bus.mem_wdata, b.wdata);
          end
        end else begin
          checkOutput("bus_addr_stable", bus.mem_addr, first_addr);
        end
        req_cycles++;
        checkOutput("stall_in_bus", {31'd0, stall, req_ready}, 32'd2);
        if (ack_mode == 1) begin
          bus.mem_ack = 1'b0;
        end else if (wait_left == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = bus_mem[bus.mem_addr[5:2]];
          if (bus.mem_we)
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[i]) bus_mem[bus.mem_addr[5:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
          last_req_cycles = req_cycles;
          busy = 0;
        end else begin
          wait_left--;
          bus.mem_ack = 1'b0;
        end
      end else begin
        busy = 0;
        bus.mem_ack = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Response monitor: every resp_valid must match the oldest queued response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          checkOutput("resp_rdata", resp_rdata, r.rdata);
`ifdef LSU_MISALIGN_TRAP_EN
          checkOutput("resp_misaligned", 32'(misaligned), 32'(r.mis));
`endif
        end
        checkOutput("stall_in_resp", {31'd0, stall, req_ready}, 32'd0);
        last_resp_cycle = cycle;
        resp_count++;
      end
    end
  end

  initial begin
    logic hb;
    bus_t b;
    resp_t r;
    logic [7:0] rb;
    logic [2:0] f3;
    logic st;

    reset = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      rb = 8'($urandom);
      ref_mem[i] = rb;
      bus_mem[i/4][8*(i%4) +: 8] = rb;
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("rst_mem_be", 32'(bus.mem_be), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Word store with an immediate ack: response two cycles after accept.
    force_delay = 0;
    applyStimulus(1'b1, 3'd2, 32'h100, 32'hdeadbeef);
    checkOutput("lat_min", 32'(last_resp_cycle - issue_cycle), 32'd2);
    force_delay = -1;

    // Byte loads, signed and unsigned, from the top lane.
    applyStimulus(1'b1, 3'd2, 32'h100, 32'h80aa55cc);
    applyStimulus(1'b0, 3'd0, 32'h103, 32'h0);
    applyStimulus(1'b0, 3'd4, 32'h103, 32'h0);

    // Halfword store to the upper lanes, then halfword loads.
    applyStimulus(1'b1, 3'd1, 32'h102, 32'h00001234);
    applyStimulus(1'b0, 3'd2, 32'h100, 32'h0);
    applyStimulus(1'b1, 3'd2, 32'h100, 32'h80015678);
    applyStimulus(1'b0, 3'd1, 32'h102, 32'h0);
    applyStimulus(1'b0, 3'd5, 32'h102, 32'h0);

    // Slow memory: request and stall held for five cycles.
    force_delay = 4;
    applyStimulus(1'b0, 3'd2, 32'h100, 32'h0);
    checkOutput("slow_req_cycles", 32'(last_req_cycles), 32'd5);
    checkOutput("slow_latency", 32'(last_resp_cycle - issue_cycle), 32'd6);
    force_delay = -1;

    // Reset in the middle of a bus access, followed by a late ack.
    @(negedge clk);
    ack_mode = 1;
    modelOp(1'b0, 3'd2, 32'h104, 32'h0, hb, b, r);
    bus_q.push_back(b);
    req_valid = 1'b1;
    req_store = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'h104;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd1);
    ack_mode = 2;
    repeat (2) begin
      @(negedge clk);
      checkOutput("late_ack_no_resp", {30'd0, resp_valid, bus.mem_req}, 32'd0);
    end
    ack_mode = 0;
    @(negedge clk);

    // Illegal load encoding and a misaligned word load.
    applyStimulus(1'b0, 3'd3, 32'h104, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h101, 32'h0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      applyStimulus(st, f3, 32'h100 + 32'($urandom_range(0, 63)), $urandom);
    end

    repeat (4) @(negedge clk);
    checkOutput("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    checkOutput("bus_queue_empty", 32'(bus_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
